// File: rtl/pipeline_ctrl_if.sv
// Handshake and control bundle between the LC-3b pipeline datapath and pipeline_ctrl.
// The master modport is the datapath/cache side; the slave modport is the controller.
interface pipeline_ctrl_if;
    logic        icache_resp;
    logic        dmem_access;
    logic        dcache_resp;
    logic [2:0]  id_src1;
    logic [2:0]  id_src2;
    logic        id_uses_src1;
    logic        id_uses_src2;
    logic        ex_is_load;
    logic [2:0]  ex_dest;
    logic        mem_br_taken;

    logic        icache_read;
    logic        dcache_req;
    logic        load_pc;
    logic        load_ifid;
    logic        load_idex;
    logic        load_exmem;
    logic        load_memwb;
    logic        bubble_ifid;
    logic        bubble_idex;
    logic        bubble_exmem;
    logic        pc_sel_redirect;
    logic [31:0] cycle_count;
    logic [31:0] stall_count;
    logic [31:0] bubble_count;
    logic [31:0] flush_count;

    modport master (
        output icache_resp, dmem_access, dcache_resp, id_src1, id_src2,
               id_uses_src1, id_uses_src2, ex_is_load, ex_dest, mem_br_taken,
        input  icache_read, dcache_req, load_pc, load_ifid, load_idex, load_exmem,
               load_memwb, bubble_ifid, bubble_idex, bubble_exmem, pc_sel_redirect,
               cycle_count, stall_count, bubble_count, flush_count
    );

    modport slave (
        input  icache_resp, dmem_access, dcache_resp, id_src1, id_src2,
               id_uses_src1, id_uses_src2, ex_is_load, ex_dest, mem_br_taken,
        output icache_read, dcache_req, load_pc, load_ifid, load_idex, load_exmem,
               load_memwb, bubble_ifid, bubble_idex, bubble_exmem, pc_sel_redirect,
               cycle_count, stall_count, bubble_count, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage LC-3b sequencing controller: cache handshake tracking, load-use stalls, redirects.
// Define PIPE_PERF_CNT_EN to build the four 32-bit performance counters; otherwise they read 0.
module pipeline_ctrl (
    input  logic            clk,
    input  logic            reset,
    pipeline_ctrl_if.slave  bus
);
    typedef enum logic {ST_RUN, ST_WAIT} state_e;

    state_e state_q;
    logic   imem_done_q, imem_done_d;
    logic   dmem_done_q, dmem_done_d;

    logic   imem_held, dmem_held;
    logic   i_ok, d_ok, advance;
    logic   load_use, redirect;

    // Flags can only be set by a stalled cycle, so they are only live while waiting.
    assign imem_held = (state_q == ST_WAIT) & imem_done_q;
    assign dmem_held = (state_q == ST_WAIT) & dmem_done_q;

    assign i_ok     = imem_held | bus.icache_resp;
    assign d_ok     = ~bus.dmem_access | dmem_held | bus.dcache_resp;
    assign advance  = i_ok & d_ok;
    assign redirect = advance & bus.mem_br_taken;
    assign load_use = bus.ex_is_load &
                      ((bus.id_uses_src1 & (bus.id_src1 == bus.ex_dest)) |
                       (bus.id_uses_src2 & (bus.id_src2 == bus.ex_dest)));

    assign bus.icache_read = ~imem_held;
    assign bus.dcache_req  = bus.dmem_access & ~dmem_held;

    always_comb begin
        imem_done_d = imem_held | bus.icache_resp;
        dmem_done_d = dmem_held | (bus.dcache_resp & bus.dmem_access);
        if (advance) begin
            imem_done_d = 1'b0;
            dmem_done_d = 1'b0;
        end
    end

    always_comb begin
        bus.load_pc         = 1'b0;
        bus.load_ifid       = 1'b0;
        bus.load_idex       = 1'b0;
        bus.load_exmem      = 1'b0;
        bus.load_memwb      = 1'b0;
        bus.bubble_ifid     = 1'b0;
        bus.bubble_idex     = 1'b0;
        bus.bubble_exmem    = 1'b0;
        bus.pc_sel_redirect = 1'b0;
        if (advance) begin
            bus.load_idex  = 1'b1;
            bus.load_exmem = 1'b1;
            bus.load_memwb = 1'b1;
            if (redirect) begin
                bus.load_pc         = 1'b1;
                bus.load_ifid       = 1'b1;
                bus.bubble_ifid     = 1'b1;
                bus.bubble_idex     = 1'b1;
                bus.bubble_exmem    = 1'b1;
                bus.pc_sel_redirect = 1'b1;
            end else if (load_use) begin
                // PC and IF/ID hold so the dependent instruction re-enters ID next cycle.
                bus.bubble_idex = 1'b1;
            end else begin
                bus.load_pc   = 1'b1;
                bus.load_ifid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= advance ? ST_RUN : ST_WAIT;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cycle_q, stall_q, bubble_q, flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q  <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (!advance)
                stall_q <= stall_q + 32'd1;
            if (redirect)
                flush_q <= flush_q + 32'd1;
            if (advance && !redirect && load_use)
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bus.cycle_count  = cycle_q;
    assign bus.stall_count  = stall_q;
    assign bus.bubble_count = bubble_q;
    assign bus.flush_count  = flush_q;
`else
    assign bus.cycle_count  = 32'd0;
    assign bus.stall_count  = 32'd0;
    assign bus.bubble_count = 32'd0;
    assign bus.flush_count  = 32'd0;
`endif
endmodule
